// File: rtl/aes_256_stream_adapter_if.sv
// Handshake bundle between the AES stream adapter and its producer/consumer.
// The master side offers plaintext/key pairs and drains ciphertext.
interface aes_256_stream_adapter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [255:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_state, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_state, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_256_stream_adapter.sv
// Valid/ready wrapper around a fixed-latency, non-stallable AES-256 pipeline.
// Credits cover in-flight blocks plus stored results, so the output FIFO can never overflow.
module aes_256_stream_adapter #(
    parameter int LATENCY    = 108,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                              clk,
    input  logic                              rst,
    aes_256_stream_adapter_if.slave           bus,
    output logic [127:0]                      core_state,
    output logic [255:0]                      core_key,
    input  logic [127:0]                      core_out,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   credits_used,
    output logic                              err_ovf
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef logic [PW-1:0] ptr_t;

    logic               acc, pop, v0, tap, wr, full;
    logic [LATENCY-1:0] vline;
    logic [127:0]       mem [FIFO_DEPTH];
    logic [127:0]       head;
    ptr_t               rd_ptr, wr_ptr, rd_ptr_nx, wr_ptr_nx;
    logic [CW-1:0]      count, count_nx;

    assign bus.in_ready  = credits_used < CW'(FIFO_DEPTH);
    assign bus.out_valid = count != '0;
    assign bus.out_data  = head;
    assign acc  = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;
    assign tap  = vline[LATENCY-1];
    assign full = count == CW'(FIFO_DEPTH);
    assign wr   = tap & (~full | pop);

    function automatic ptr_t bump(input ptr_t p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        rd_ptr_nx = pop ? bump(rd_ptr) : rd_ptr;
        wr_ptr_nx = wr ? bump(wr_ptr) : wr_ptr;
        count_nx  = count;
        if (wr && !pop)
            count_nx = count + CW'(1);
        else if (pop && !wr)
            count_nx = count - CW'(1);
    end

    // Idle cycles feed zeros to the core; v0 marks which core cycles carry real blocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_state <= '0;
            core_key   <= '0;
            v0         <= 1'b0;
            vline      <= '0;
        end else begin
            core_state <= acc ? bus.in_state : '0;
            core_key   <= acc ? bus.in_key : '0;
            v0         <= acc;
            vline      <= {vline[LATENCY-2:0], v0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            credits_used <= '0;
        else if (acc && !pop)
            credits_used <= credits_used + CW'(1);
        else if (pop && !acc)
            credits_used <= credits_used - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wr_ptr] <= core_out;
    end

    // Head is registered; a write landing in the next head slot bypasses the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            head    <= '0;
            err_ovf <= 1'b0;
        end else begin
            rd_ptr <= rd_ptr_nx;
            wr_ptr <= wr_ptr_nx;
            count  <= count_nx;
            if (count_nx != '0)
                head <= (wr && wr_ptr == rd_ptr_nx) ? core_out : mem[rd_ptr_nx];
            if (tap && full && !pop)
                err_ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_aes_256_stream_adapter.sv
// Scoreboard bench for aes_256_stream_adapter with a behavioural fixed-latency AES-256 core.
// Expected ciphertexts are queued at accept time and compared in order at each pop.
module tb_aes_256_stream_adapter;
    localparam int LAT   = 108;
    localparam int DEPTH = 128;
    localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] core_state, core_out;
    logic [255:0] core_key;
    logic [7:0]   credits_used;
    logic         err_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic [127:0] exp_q [$];

    aes_256_stream_adapter_if bus();

    aes_256_stream_adapter #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .core_state(core_state),
        .core_key(core_key),
        .core_out(core_out),
        .credits_used(credits_used),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++)
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                      {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes256(input logic [127:0] pt, input logic [255:0] key);
        logic [31:0]  w [60];
        logic [31:0]  t;
        logic [127:0] s, u;
        logic [7:0]   rc, a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        for (int r = 1; r <= 14; r++) begin
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++)
                    u[127-8*(q+4*c) -: 8] = sbox[s[127-8*(q+4*((c+q)%4)) -: 8]];
            if (r != 14) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = u[127-32*c -: 8];
                    a1 = u[119-32*c -: 8];
                    a2 = u[111-32*c -: 8];
                    a3 = u[103-32*c -: 8];
                    s[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                         a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                         a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                         xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
                end
            end else begin
                s = u;
            end
            s = s ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
        return s;
    endfunction

    // Non-stallable core stand-in: no reset, result appears LAT cycles after presentation.
    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= aes256(core_state, core_key);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LAT-1];

    function automatic logic [127:0] r128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [255:0] r256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // Drives one cycle, reports the handshakes that the next edge completes, and updates the scoreboard.
    task automatic drive_cycle(input logic iv, input logic [127:0] st, input logic [255:0] k,
                               input logic ordy, output logic acc, output logic popd,
                               output logic [127:0] got, output logic have, output logic [127:0] exp);
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_state  = st;
        bus.in_key    = k;
        bus.out_ready = ordy;
        #1;
        acc  = bus.in_valid && bus.in_ready;
        popd = bus.out_valid && bus.out_ready;
        got  = bus.out_data;
        have = 1'b0;
        exp  = '0;
        if (popd && exp_q.size() > 0) begin
            have = 1'b1;
            exp  = exp_q.pop_front();
        end
        if (acc) exp_q.push_back(aes256(st, k));
        cyc++;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_state = '0; bus.in_key = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_out_data got=%h want=0", bus.out_data); end
        n_checks++; if (core_state !== '0) begin n_fail++; $display("[TB] FAIL reset_core_state got=%h want=0", core_state); end
        n_checks++; if (core_key !== '0) begin n_fail++; $display("[TB] FAIL reset_core_key got=%h want=0", core_key); end
        n_checks++; if (credits_used !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_credits got=%0d want=0", credits_used); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err_ovf got=%b want=0", err_ovf); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_fips();
        logic acc, popd, have;
        logic [127:0] got, exp;
        int t0, t_out, npop;
        t_out = -1; npop = 0;
        drive_cycle(1'b1, FIPS_PT, FIPS_KEY, 1'b1, acc, popd, got, have, exp);
        t0 = cyc;
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL fips_accept got=%b want=1", acc); end
        drive_cycle(1'b0, '0, '0, 1'b1, acc, popd, got, have, exp);
        n_checks++; if (core_state !== FIPS_PT) begin n_fail++; $display("[TB] FAIL fips_core_state got=%h want=%h", core_state, FIPS_PT); end
        n_checks++; if (core_key !== FIPS_KEY) begin n_fail++; $display("[TB] FAIL fips_core_key got=%h want=%h", core_key, FIPS_KEY); end
        for (int i = 0; i < 250; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b1, acc, popd, got, have, exp);
            if (popd) begin
                npop++;
                if (t_out < 0) t_out = cyc;
                n_checks++; if (got !== FIPS_CT) begin n_fail++; $display("[TB] FAIL fips_data got=%h want=%h", got, FIPS_CT); end
            end
        end
        n_checks++; if (npop != 1) begin n_fail++; $display("[TB] FAIL fips_pop_count got=%0d want=1", npop); end
        n_checks++; if (t_out - t0 != LAT + 2) begin n_fail++; $display("[TB] FAIL fips_latency got=%0d want=%0d", t_out - t0, LAT + 2); end
    endtask

    task automatic test_streaming();
        logic acc, popd, have, iv;
        logic [127:0] got, exp, st;
        logic [255:0] k;
        int sent, guard, low, npop, first, last;
        sent = 0; guard = 0; low = 0; npop = 0; first = -1; last = -1;
        st = r128(); k = r256();
        while ((sent < 500 || exp_q.size() > 0) && guard < 3000) begin
            iv = (sent < 500);
            drive_cycle(iv, st, k, 1'b1, acc, popd, got, have, exp);
            guard++;
            if (iv && !acc) low++;
            if (acc) begin sent++; st = r128(); k = r256(); end
            if (popd) begin
                npop++;
                if (first < 0) first = cyc;
                last = cyc;
                n_checks++; if (!have || got !== exp) begin n_fail++; $display("[TB] FAIL stream_data got=%h want=%h", got, exp); end
            end
        end
        n_checks++; if (low != 0) begin n_fail++; $display("[TB] FAIL stream_in_ready_low got=%0d cycles want=0", low); end
        n_checks++; if (npop != 500) begin n_fail++; $display("[TB] FAIL stream_count got=%0d want=500", npop); end
        n_checks++; if (last - first + 1 != 500) begin n_fail++; $display("[TB] FAIL stream_contiguous got=%0d want=500", last - first + 1); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL stream_err_ovf got=%b want=0", err_ovf); end
    endtask

    task automatic test_backpressure();
        logic acc, popd, have, iv;
        logic [127:0] got, exp, st;
        logic [255:0] k;
        int sent, guard, early, npop;
        sent = 0; guard = 0; early = 0; npop = 0;
        st = r128(); k = r256();
        for (int i = 0; i < 300; i++) begin
            iv = (sent < 200);
            drive_cycle(iv, st, k, 1'b0, acc, popd, got, have, exp);
            if (acc) begin sent++; st = r128(); k = r256(); end
            if (popd) early++;
        end
        n_checks++; if (sent != DEPTH) begin n_fail++; $display("[TB] FAIL bp_accepts got=%0d want=%0d", sent, DEPTH); end
        n_checks++; if (credits_used !== 8'(DEPTH)) begin n_fail++; $display("[TB] FAIL bp_credits got=%0d want=%0d", credits_used, DEPTH); end
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready got=%b want=0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_out_valid got=%b want=1", bus.out_valid); end
        n_checks++; if (early != 0) begin n_fail++; $display("[TB] FAIL bp_early_pops got=%0d want=0", early); end
        while ((sent < 200 || exp_q.size() > 0) && guard < 1000) begin
            iv = (sent < 200);
            drive_cycle(iv, st, k, 1'b1, acc, popd, got, have, exp);
            guard++;
            if (acc) begin sent++; st = r128(); k = r256(); end
            if (popd) begin
                npop++;
                n_checks++; if (!have || got !== exp) begin n_fail++; $display("[TB] FAIL bp_data got=%h want=%h", got, exp); end
            end
        end
        n_checks++; if (npop != 200) begin n_fail++; $display("[TB] FAIL bp_drain_count got=%0d want=200", npop); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_err_ovf got=%b want=0", err_ovf); end
    endtask

    task automatic test_simultaneous();
        logic acc, popd, have, prev_pop;
        logic [127:0] got, exp, st;
        logic [255:0] k;
        int guard;
        guard = 0; prev_pop = 1'b0;
        st = r128(); k = r256();
        for (int i = 0; i < 260; i++) begin
            drive_cycle(1'b1, st, k, 1'b0, acc, popd, got, have, exp);
            if (acc) begin st = r128(); k = r256(); end
        end
        n_checks++; if (credits_used !== 8'(DEPTH)) begin n_fail++; $display("[TB] FAIL sim_fill_credits got=%0d want=%0d", credits_used, DEPTH); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_fill_out_valid got=%b want=1", bus.out_valid); end
        for (int i = 0; i < 40; i++) begin
            drive_cycle(1'b1, st, k, (i % 2 == 0), acc, popd, got, have, exp);
            if (acc) begin st = r128(); k = r256(); end
            n_checks++; if (credits_used < 8'd127 || credits_used > 8'd128) begin n_fail++; $display("[TB] FAIL sim_credits got=%0d want=127..128", credits_used); end
            if (prev_pop) begin
                n_checks++; if (acc !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_accept_after_pop got=%b want=1", acc); end
            end
            prev_pop = popd;
            if (popd) begin
                n_checks++; if (!have || got !== exp) begin n_fail++; $display("[TB] FAIL sim_data got=%h want=%h", got, exp); end
            end
        end
        while (exp_q.size() > 0 && guard < 600) begin
            drive_cycle(1'b0, '0, '0, 1'b1, acc, popd, got, have, exp);
            guard++;
            if (popd) begin
                n_checks++; if (!have || got !== exp) begin n_fail++; $display("[TB] FAIL sim_drain_data got=%h want=%h", got, exp); end
            end
        end
        drive_cycle(1'b0, '0, '0, 1'b1, acc, popd, got, have, exp);
        n_checks++; if (credits_used !== 8'd0) begin n_fail++; $display("[TB] FAIL sim_final_credits got=%0d want=0", credits_used); end
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL sim_final_out_valid got=%b want=0", bus.out_valid); end
    endtask

    task automatic test_reset_midstream();
        logic acc, popd, have;
        logic [127:0] got, exp;
        int t0, t_out, npop;
        t_out = -1; npop = 0;
        for (int i = 0; i < 50; i++) drive_cycle(1'b1, r128(), r256(), 1'b1, acc, popd, got, have, exp);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, '0, 1'b1, acc, popd, got, have, exp);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_out_valid got=%b want=0", bus.out_valid); end
        n_checks++; if (bus.out_data !== '0) begin n_fail++; $display("[TB] FAIL mid_rst_out_data got=%h want=0", bus.out_data); end
        n_checks++; if (credits_used !== 8'd0) begin n_fail++; $display("[TB] FAIL mid_rst_credits got=%0d want=0", credits_used); end
        n_checks++; if (core_state !== '0 || core_key !== '0) begin n_fail++; $display("[TB] FAIL mid_rst_core got=%h want=0", core_state); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_rst_err_ovf got=%b want=0", err_ovf); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL mid_rst_in_ready got=%b want=1", bus.in_ready); end
        drive_cycle(1'b1, FIPS_PT, FIPS_KEY, 1'b1, acc, popd, got, have, exp);
        t0 = cyc;
        for (int i = 0; i < 250; i++) begin
            drive_cycle(1'b0, '0, '0, 1'b1, acc, popd, got, have, exp);
            if (popd) begin
                npop++;
                if (t_out < 0) t_out = cyc;
                n_checks++; if (got !== FIPS_CT) begin n_fail++; $display("[TB] FAIL mid_data got=%h want=%h", got, FIPS_CT); end
            end
        end
        n_checks++; if (npop != 1) begin n_fail++; $display("[TB] FAIL mid_pop_count got=%0d want=1", npop); end
        n_checks++; if (t_out - t0 != LAT + 2) begin n_fail++; $display("[TB] FAIL mid_latency got=%0d want=%0d", t_out - t0, LAT + 2); end
    endtask

    task automatic test_random();
        logic acc, popd, have, iv, ordy;
        logic [127:0] got, exp, st;
        logic [255:0] k;
        int sent, guard, npop, over;
        sent = 0; guard = 0; npop = 0; over = 0;
        st = r128(); k = r256();
        while ((sent < 1000 || exp_q.size() > 0) && guard < 9000) begin
            iv   = (sent < 1000) && ($urandom_range(0, 1) == 1);
            ordy = (sent >= 1000) || ($urandom_range(0, 1) == 1);
            drive_cycle(iv, st, k, ordy, acc, popd, got, have, exp);
            guard++;
            if (credits_used > 8'(DEPTH)) over++;
            if (acc) begin sent++; st = r128(); k = r256(); end
            if (popd) begin
                npop++;
                n_checks++; if (!have || got !== exp) begin n_fail++; $display("[TB] FAIL rand_data got=%h want=%h", got, exp); end
            end
        end
        n_checks++; if (npop != 1000) begin n_fail++; $display("[TB] FAIL rand_count got=%0d want=1000", npop); end
        n_checks++; if (over != 0) begin n_fail++; $display("[TB] FAIL rand_credit_limit got=%0d cycles over want=0", over); end
        n_checks++; if (err_ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_err_ovf got=%b want=0", err_ovf); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=completion");
        $fatal(1, "[TB] simulation time limit reached");
    end
endmodule
